// File: rtl/vproc_hazard_tracker.sv
// Vector register write-hazard scoreboard: records each dispatched instruction's write set
// by ID, stalls dispatch on RAW/WAW/ID-reuse conflicts, and releases write sets on retire.
module vproc_hazard_tracker #(
  parameter int unsigned INSTR_ID_W     = 3,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       async_rst_i,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [INSTR_ID_W-1:0]      dispatch_id_i,
  input  logic [31:0]                dispatch_rd_hazards_i,
  input  logic [31:0]                dispatch_wr_hazards_i,
  input  logic                       retire_valid_i,
  input  logic [INSTR_ID_W-1:0]      retire_id_i,
  output logic [31:0]                pending_wr_o,
  output logic [2**INSTR_ID_W-1:0]   id_busy_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned N = 2**INSTR_ID_W;

  logic [N-1:0] id_busy_q, id_busy_d;
  logic [31:0]  wr_mask_q [N];
  logic [31:0]  wr_mask_d [N];
  logic [31:0]  pending_wr_q, pending_wr_d;
  logic         err_q, err_d;

  logic         ret_hit;
  logic [31:0]  ret_mask;
  logic [31:0]  eff_pending;
  logic [N-1:0] eff_busy;
  logic         accept;

  // A retiring entry is released before the dispatch check, giving zero-cycle unblock.
  always_comb begin
    ret_hit     = retire_valid_i & id_busy_q[retire_id_i];
    ret_mask    = ret_hit ? wr_mask_q[retire_id_i] : '0;
    eff_pending = pending_wr_q & ~ret_mask;
    eff_busy    = id_busy_q;
    if (ret_hit) eff_busy[retire_id_i] = 1'b0;

    dispatch_ready_o = ~flush_i & ~eff_busy[dispatch_id_i]
                     & ~|((dispatch_rd_hazards_i | dispatch_wr_hazards_i) & eff_pending);
    accept = dispatch_valid_i & dispatch_ready_o;
  end

  always_comb begin
    id_busy_d    = id_busy_q;
    wr_mask_d    = wr_mask_q;
    pending_wr_d = pending_wr_q;
    err_d        = err_q;

    if (flush_i) begin
      id_busy_d    = '0;
      pending_wr_d = '0;
      if (DONT_CARE_ZERO) begin
        for (int unsigned i = 0; i < N; i++) wr_mask_d[i] = '0;
      end
    end else begin
      err_d        = err_q | (retire_valid_i & ~id_busy_q[retire_id_i]);
      id_busy_d    = eff_busy;
      pending_wr_d = eff_pending;
      if (ret_hit && DONT_CARE_ZERO) wr_mask_d[retire_id_i] = '0;
      // Install after release so a same-ID retire+dispatch keeps the new mask.
      if (accept) begin
        id_busy_d[dispatch_id_i] = 1'b1;
        wr_mask_d[dispatch_id_i] = dispatch_wr_hazards_i;
        pending_wr_d             = eff_pending | dispatch_wr_hazards_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      id_busy_q    <= '0;
      pending_wr_q <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        if (DONT_CARE_ZERO) wr_mask_q[i] <= '0;
        else                wr_mask_q[i] <= 'x;
      end
    end else begin
      id_busy_q    <= id_busy_d;
      wr_mask_q    <= wr_mask_d;
      pending_wr_q <= pending_wr_d;
      err_q        <= err_d;
    end
  end

  assign pending_wr_o = pending_wr_q;
  assign id_busy_o    = id_busy_q;
  assign busy_o       = |id_busy_q;
  assign err_o        = err_q;

  // Busy write masks are disjoint, so the aggregate must equal their OR.
  logic [31:0] busy_or;
  always_comb begin
    busy_or = '0;
    for (int unsigned i = 0; i < N; i++)
      if (id_busy_q[i]) busy_or = busy_or | wr_mask_q[i];
  end

  a_pending_matches: assert property (@(posedge clk_i) disable iff (async_rst_i)
    pending_wr_q == busy_or);

endmodule

// File: tb/tb_vproc_hazard_tracker.sv
// Scoreboard bench for vproc_hazard_tracker: a behavioural model predicts ready and
// the next-cycle registered outputs; predictions are queued and checked after each edge.
module tb_vproc_hazard_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dv = 1'b0;
  logic        dready;
  logic [2:0]  did = '0;
  logic [31:0] drd = '0;
  logic [31:0] dwr = '0;
  logic        rv = 1'b0;
  logic [2:0]  rid = '0;
  logic [31:0] pending;
  logic [7:0]  idbusy;
  logic        busy;
  logic        err;

  vproc_hazard_tracker #(.INSTR_ID_W(3), .DONT_CARE_ZERO(1'b1)) dut (
    .clk_i(clk), .async_rst_i(rst), .flush_i(flush),
    .dispatch_valid_i(dv), .dispatch_ready_o(dready), .dispatch_id_i(did),
    .dispatch_rd_hazards_i(drd), .dispatch_wr_hazards_i(dwr),
    .retire_valid_i(rv), .retire_id_i(rid),
    .pending_wr_o(pending), .id_busy_o(idbusy), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pending;
    logic [7:0]  idbusy;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model
  logic        m_busy [8];
  logic [31:0] m_mask [8];
  logic        m_err;
  logic        got_ready;

  function automatic exp_t model_outputs();
    exp_t e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e.idbusy[i] = m_busy[i];
      if (m_busy[i]) e.pending = e.pending | m_mask[i];
    end
    e.busy = |e.idbusy;
    e.err  = m_err;
    return e;
  endfunction

  function automatic logic model_ready(input logic v_fl, input logic [2:0] v_id,
      input logic [31:0] v_rd, input logic [31:0] v_wr, input logic v_rv, input logic [2:0] v_rid);
    logic ok;
    ok = !v_fl;
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i] && !(v_rv && v_rid == 3'(i))) begin
        if (v_id == 3'(i)) ok = 1'b0;
        if (((v_rd | v_wr) & m_mask[i]) != 0) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 1'b0;
      m_mask[i] = '0;
    end
    m_err = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("pending_wr", pending, e.pending);
      check_val("id_busy",    32'(idbusy), 32'(e.idbusy));
      check_val("busy",       32'(busy), 32'(e.busy));
      check_val("err",        32'(err), 32'(e.err));
    end
  end

  task automatic step(input logic v, input logic [2:0] id, input logic [31:0] rd,
      input logic [31:0] wr, input logic r_v, input logic [2:0] r_id, input logic fl);
    logic er;
    @(negedge clk);
    dv = v; did = id; drd = rd; dwr = wr; rv = r_v; rid = r_id; flush = fl;
    #1;
    got_ready = dready;
    er = model_ready(fl, id, rd, wr, r_v, r_id);
    check_val("ready", 32'(got_ready), 32'(er));
    if (fl) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    end else begin
      if (r_v) begin
        if (m_busy[r_id]) m_busy[r_id] = 1'b0;
        else m_err = 1'b1;
      end
      if (v && er) begin
        m_busy[id] = 1'b1;
        m_mask[id] = wr;
      end
    end
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #2;
    dv = 1'b0; rv = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_val("rst_pending", pending, 32'h0);
    check_val("rst_idbusy",  32'(idbusy), 32'h0);
    check_val("rst_busy",    32'(busy), 32'h0);
    check_val("rst_err",     32'(err), 32'h0);
    check_val("rst_ready",   32'(dready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Basic dispatch
    step(1'b1, 3'd0, 32'h3, 32'h0C, 1'b0, 3'd0, 1'b0);
    check_val("tp1_ready", 32'(got_ready), 32'h1);
    check_val("tp1_pending", pending, 32'h0C);
    check_val("tp1_idbusy", 32'(idbusy), 32'h01);

    // RAW, WAW, then clean dispatch
    step(1'b1, 3'd1, 32'h08, 32'h0, 1'b0, 3'd0, 1'b0);
    check_val("tp2_raw", 32'(got_ready), 32'h0);
    step(1'b1, 3'd1, 32'h0, 32'h04, 1'b0, 3'd0, 1'b0);
    check_val("tp2_waw", 32'(got_ready), 32'h0);
    step(1'b1, 3'd1, 32'h0, 32'hF0, 1'b0, 3'd0, 1'b0);
    check_val("tp2_ok", 32'(got_ready), 32'h1);
    check_val("tp2_pending", pending, 32'hFC);

    // Same-cycle retire+dispatch of one ID
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 32'h0, 32'hFF00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd2, 32'h0100, 32'h0F00, 1'b1, 3'd2, 1'b0);
    check_val("tp3_bypass", 32'(got_ready), 32'h1);
    check_val("tp3_pending", pending, 32'h0F00);
    check_val("tp3_idbusy", 32'(idbusy), 32'h04);

    // Full table, ID reuse stall, bypass unblock
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 32'h0, 32'h1 << i, 1'b0, 3'd0, 1'b0);
    check_val("tp4_full", 32'(idbusy), 32'hFF);
    step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    check_val("tp4_idstall", 32'(got_ready), 32'h0);
    step(1'b1, 3'd3, 32'h0, 32'h0, 1'b1, 3'd3, 1'b0);
    check_val("tp4_idbypass", 32'(got_ready), 32'h1);
    check_val("tp4_pending", pending, 32'hF7);

    // Retire of non-busy ID sets sticky err
    do_reset();
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5, 1'b0);
    check_val("tp5_err", 32'(err), 32'h1);
    check_val("tp5_idbusy", 32'(idbusy), 32'h0);
    step(1'b1, 3'd1, 32'h0, 32'h10, 1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    check_val("tp5_err_hold", 32'(err), 32'h1);

    // Flush with retire of a non-busy ID: no err, table cleared
    do_reset();
    step(1'b1, 3'd0, 32'h0, 32'h1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd1, 32'h0, 32'h2, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd2, 32'h0, 32'h4, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd3, 32'h0, 32'h8, 1'b1, 3'd7, 1'b1);
    check_val("tp6_flush_ready", 32'(got_ready), 32'h0);
    check_val("tp6_pending", pending, 32'h0);
    check_val("tp6_idbusy", 32'(idbusy), 32'h0);
    check_val("tp6_err", 32'(err), 32'h0);

    // Mid-cycle async reset clears outputs without a clock edge
    step(1'b1, 3'd4, 32'h0, 32'h30, 1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd6, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("tp7_pending", pending, 32'h0);
    check_val("tp7_idbusy", 32'(idbusy), 32'h0);
    check_val("tp7_err", 32'(err), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r_rd, r_wr;
      r_rd = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 11));
      r_wr = ($urandom_range(0, 4) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 11));
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), r_rd, r_wr,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 40) == 0));
    end

    @(negedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
